// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 registered selector: mode encodings and
// the select-width derivation used by every file of the block.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single channel still needs a one-bit index port.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1,
// found by rotating a doubled request vector and priority-encoding the window.
module rr_pick
  import mux_pkg::*;
#(
  parameter int  CHANNELS = 4,
  localparam int SELW     = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     last,
  output logic [SELW-1:0]     gnt_idx,
  output logic                gnt_any
);

  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_win;
  int                    w_start;
  int                    w_off;

  always_comb begin
    w_start = int'(last) + 1;
    if (w_start >= CHANNELS) w_start = 0;
    w_dbl = {req, req};
    w_win = CHANNELS'(w_dbl >> w_start);
    w_off = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_win[i]) w_off = i;
    end
    gnt_any = |req;
    gnt_idx = SELW'((w_start + w_off) % CHANNELS);
  end

endmodule

// File: rtl/mux_nt1_reg.sv
// N-to-1 selector with a single registered output stage and valid/ready on
// every channel; fixed-select or round-robin arbitration.
module mux_nt1_reg
  import mux_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  CHANNELS = 4,
  localparam int SELW     = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_ch,
  input  logic                      out_ready
);

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic [SELW-1:0]  r_ch_p1;
  logic [SELW-1:0]  r_last;

  logic [SELW-1:0]     w_rr_idx;
  logic                w_rr_any;
  logic [SELW-1:0]     w_gnt_idx;
  logic                w_gnt_any;
  logic                w_can_load;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_ready;
  logic [WIDTH-1:0]    w_sel_data;

  rr_pick #(.CHANNELS(CHANNELS)) u_rr (
    .req     (in_valid),
    .last    (r_last),
    .gnt_idx (w_rr_idx),
    .gnt_any (w_rr_any)
  );

  // Stage p0: grant selection; an out-of-range fixed select matches no channel
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (mode == MODE_RR) begin
      w_gnt_any = w_rr_any;
      w_gnt_idx = w_rr_idx;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (CHANNELS == 1 || int'(sel) == k) begin
          w_gnt_any = in_valid[k];
          w_gnt_idx = SELW'(k);
        end
      end
    end
  end

  assign w_can_load = !r_vld_p1 || out_ready;
  assign w_xfer     = w_gnt_any && w_can_load && !rst;

  always_comb begin
    w_ready    = '0;
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(w_gnt_idx) == k) begin
        w_ready[k] = w_xfer;
        w_sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage p1: output register; a load and a drain in the same cycle overlap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_ch_p1   <= '0;
      r_last    <= SELW'(CHANNELS - 1);
    end else if (w_xfer) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_sel_data;
      r_ch_p1   <= w_gnt_idx;
      r_last    <= w_gnt_idx;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_ch    = r_ch_p1;

endmodule
